// File: rtl/array_input_collector_pkg.sv
// Shared definitions for the client keypad-array collector.
//   - Button press codes (level codes driven by the keypad decoder).
//   - Collector FSM state encoding.
//   - clamp_target(): maps a requested digit count into 1..max_digits.
package array_input_collector_pkg;

  localparam logic [2:0] PRESS_NXT  = 3'b000;
  localparam logic [2:0] PRESS_RLS  = 3'b001;
  localparam logic [2:0] PRESS_CON  = 3'b010;
  localparam logic [2:0] PRESS_DEL  = 3'b011;
  localparam logic [2:0] PRESS_RIS  = 3'b100;
  localparam logic [2:0] PRESS_NONE = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } aic_state_e;

  // A request of 0 digits still needs one digit to complete; anything
  // above the storage depth is capped at the storage depth.
  function automatic logic [2:0] clamp_target(input logic [3:0] t, input int max_digits);
    if (t == 4'd0)
      return 3'd1;
    else if (int'(t) > max_digits)
      return 3'(max_digits);
    else
      return t[2:0];
  endfunction

endpackage

// File: rtl/array_input_collector_press_edge_detect.sv
// press_edge_detect: turns a level button code into a one-cycle action strobe.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear of the press history (history = none)
//   press      : current level code from the keypad
//   strobe     : high for the single cycle where press != none and the
//                registered previous code was none
//   code       : the code that accompanies strobe (pass-through of press)
module press_edge_detect
  import array_input_collector_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic [2:0] press,
  output logic       strobe,
  output logic [2:0] code
);

  logic [2:0] prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   prev <= PRESS_NONE;
    else if (clr) prev <= PRESS_NONE;
    else          prev <= press;
  end

  // Combinational so the action lands on the first edge the code is seen.
  assign strobe = !clr && (press != PRESS_NONE) && (prev == PRESS_NONE);
  assign code   = press;

endmodule

// File: rtl/array_input_collector.sv
// array_input_collector: responder side of the keypad-array handshake.
// Gathers a right-aligned BCD entry of up to MAX_DIGITS digits for a
// requesting screen FSM and drives the low 20 bits of the shared 7-seg bus.
//   clk, rst_n    : clock, async active-low reset
//   en            : request; low = idle, array_o/show_o released ('z)
//   target_count  : digits wanted, sampled when the request starts
//   press, switch : button level code, switch[3:0] = digit to enter
//   over_o        : entry complete, held until en falls
//   array_o       : digits, newest in [3:0]
//   count_o       : digits currently held
//   show_o        : four 5-bit display codes, newest rightmost
// Build option: ARRAY_MASK_EN -> filled display positions show MASK_CHAR.
module array_input_collector
  import array_input_collector_pkg::*;
#(
  parameter int         MAX_DIGITS = 5,
  parameter logic [4:0] BLANK_CHAR = 5'd31,
  parameter logic [4:0] MASK_CHAR  = 5'd30
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [3:0]              target_count,
  input  logic [2:0]              press,
  input  logic [7:0]              switch,
  output logic                    over_o,
  output logic [4*MAX_DIGITS-1:0] array_o,
  output logic [2:0]              count_o,
  output logic [19:0]             show_o
);

  localparam int AW = 4 * MAX_DIGITS;

  aic_state_e      state, nxt_state;
  logic [2:0]      tgt;
  logic [2:0]      cnt;
  logic [AW-1:0]   arr;
  logic            strobe;
  logic [2:0]      code;
  logic [19:0]     show_int;

  logic unused_switch_hi;
  assign unused_switch_hi = ^switch[7:4];

  press_edge_detect u_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (!en),
    .press  (press),
    .strobe (strobe),
    .code   (code)
  );

  logic in_collect, digit_ok, act_con, act_del, act_ris;
  assign in_collect = en && (state == ST_COLLECT);
  assign digit_ok   = (switch[3:0] <= 4'd9);
  assign act_con    = in_collect && strobe && (code == PRESS_CON) && digit_ok;
  assign act_del    = in_collect && strobe && (code == PRESS_DEL) && (cnt != 3'd0);
  assign act_ris    = in_collect && strobe && (code == PRESS_RIS);

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nxt_state;
  end

  // FSM: next state; en low wins over anything else in the same cycle
  always_comb begin
    nxt_state = state;
    if (!en) begin
      nxt_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    nxt_state = ST_COLLECT;
        ST_COLLECT: if (act_con && (cnt + 3'd1 == tgt)) nxt_state = ST_DONE;
        ST_DONE:    nxt_state = ST_DONE;
        default:    nxt_state = ST_IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    over_o  = (state == ST_DONE);
    count_o = cnt;
  end

  // Digit store; only COLLECT modifies it, so DONE leaves it frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt <= 3'd1;
      cnt <= 3'd0;
      arr <= '0;
    end else if (!en) begin
      cnt <= 3'd0;
      arr <= '0;
    end else if (state == ST_IDLE) begin
      tgt <= clamp_target(target_count, MAX_DIGITS);
      cnt <= 3'd0;
      arr <= '0;
    end else if (act_con) begin
      arr <= {arr[AW-5:0], switch[3:0]};
      cnt <= cnt + 3'd1;
    end else if (act_del) begin
      arr <= arr >> 4;
      cnt <= cnt - 3'd1;
    end else if (act_ris) begin
      arr <= '0;
      cnt <= 3'd0;
    end
  end

  // Display mux: position i is filled when fewer than cnt digits sit to its right.
  for (genvar i = 0; i < 4; i++) begin : g_show
`ifdef ARRAY_MASK_EN
    assign show_int[5*i +: 5] = (cnt > 3'(i)) ? MASK_CHAR : BLANK_CHAR;
    logic unused_digit;
    assign unused_digit = ^arr[4*i +: 4];
`else
    assign show_int[5*i +: 5] = (cnt > 3'(i)) ? {1'b0, arr[4*i +: 4]} : BLANK_CHAR;
`endif
  end

  // Shared bus: release while no screen is requesting.
  assign array_o = en ? arr      : 'z;
  assign show_o  = en ? show_int : 'z;

endmodule

// File: tb/tb_array_input_collector.sv
module tb_array_input_collector;
  import array_input_collector_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  target_count = 4'd0;
  logic [2:0]  press = PRESS_NONE;
  logic [7:0]  switch = 8'd0;
  logic        over_o;
  wire  [19:0] array_o;
  logic [2:0]  count_o;
  wire  [19:0] show_o;

  array_input_collector dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .target_count (target_count),
    .press        (press),
    .switch       (switch),
    .over_o       (over_o),
    .array_o      (array_o),
    .count_o      (count_o),
    .show_o       (show_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: the entry as a list of digits, oldest first.
  int digs[$];
  int tgt;
  bit done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] exp_array();
    logic [19:0] a = '0;
    foreach (digs[i]) a = {a[15:0], 4'(digs[i])};
    return a;
  endfunction

  function automatic logic [19:0] exp_show();
    logic [19:0] s = '0;
    int n = digs.size();
    for (int i = 0; i < 4; i++) begin
      if (i < n) begin
`ifdef ARRAY_MASK_EN
        s[5*i +: 5] = 5'd30;
`else
        s[5*i +: 5] = {1'b0, 4'(digs[n-1-i])};
`endif
      end else begin
        s[5*i +: 5] = 5'd31;
      end
    end
    return s;
  endfunction

  task automatic model_apply(input logic [2:0] c, input logic [7:0] sw);
    if (done) return;
    case (c)
      PRESS_CON: if (sw[3:0] <= 4'd9) begin
        digs.push_back(int'(sw[3:0]));
        if (digs.size() == tgt) done = 1'b1;
      end
      PRESS_DEL: if (digs.size() > 0) void'(digs.pop_back());
      PRESS_RIS: digs.delete();
      default: ;
    endcase
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/over"},  32'(over_o),  32'(done));
    chk({tag, "/count"}, 32'(count_o), 32'(digs.size()));
    chk({tag, "/array"}, 32'(array_o), 32'(exp_array()));
    chk({tag, "/show"},  32'(show_o),  32'(exp_show()));
  endtask

  task automatic start(input int t);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("idle/over", 32'(over_o), 32'd0);
    chk("idle/count", 32'(count_o), 32'd0);
    en = 1'b1;
    target_count = 4'(t);
    @(negedge clk);
    digs.delete();
    done = 1'b0;
    tgt = (t == 0) ? 1 : (t > 5) ? 5 : t;
    check_all("start");
  endtask

  task automatic press_btn(input logic [2:0] c, input logic [7:0] sw, input int hold);
    @(negedge clk);
    press = c;
    switch = sw;
    repeat (hold) @(negedge clk);
    press = PRESS_NONE;
    model_apply(c, sw);
    check_all("press");
  endtask

  logic [2:0] codes [7] = '{PRESS_NXT, PRESS_RLS, PRESS_CON, PRESS_CON,
                           PRESS_CON, PRESS_DEL, PRESS_RIS};

  initial begin
    // reset state
    #12;
    chk("rst/over", 32'(over_o), 32'd0);
    chk("rst/count", 32'(count_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // four digits, target 4
    start(4);
    for (int d = 1; d <= 4; d++) press_btn(PRESS_CON, 8'(d), 1);
    chk("t1/array", 32'(array_o), 32'h01234);
    chk("t1/over", 32'(over_o), 32'd1);

    // delete mid-entry, delete at empty
    start(4);
    press_btn(PRESS_DEL, 8'd0, 1);
    press_btn(PRESS_CON, 8'd5, 1);
    press_btn(PRESS_CON, 8'd6, 1);
    press_btn(PRESS_DEL, 8'd0, 1);
    press_btn(PRESS_CON, 8'd7, 1);
    press_btn(PRESS_CON, 8'd8, 1);
    press_btn(PRESS_CON, 8'd9, 1);
    chk("t2/array", 32'(array_o), 32'h05789);

    // held button acts once; non-BCD digit ignored
    start(5);
    press_btn(PRESS_CON, 8'd3, 50);
    chk("t3/count", 32'(count_o), 32'd1);
    press_btn(PRESS_CON, 8'hFA, 1);
    chk("t3/count_a", 32'(count_o), 32'd1);

    // target clamping and frozen DONE
    start(0);
    press_btn(PRESS_CON, 8'd7, 1);
    chk("t4/over0", 32'(over_o), 32'd1);
    start(9);
    for (int d = 0; d < 5; d++) press_btn(PRESS_CON, 8'(d + 2), 1);
    chk("t4/over9", 32'(over_o), 32'd1);
    press_btn(PRESS_CON, 8'd1, 1);
    press_btn(PRESS_DEL, 8'd0, 1);
    press_btn(PRESS_RIS, 8'd0, 1);
    chk("t4/frozen", 32'(array_o), 32'h23456);

    // en drop mid-entry restarts clean
    start(5);
    press_btn(PRESS_CON, 8'd4, 1);
    press_btn(PRESS_CON, 8'd2, 1);
    start(5);
    chk("t5/array", 32'(array_o), 32'd0);

    // reset pulse mid-entry discards digits
    press_btn(PRESS_CON, 8'd8, 1);
    press_btn(PRESS_CON, 8'd1, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6/count", 32'(count_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    digs.delete();
    done = 1'b0;
    check_all("t6");

    // randomized sessions
    for (int s = 0; s < 40; s++) begin
      start(int'($urandom_range(0, 15)));
      for (int k = 0; k < 12; k++) begin
        press_btn(codes[$urandom_range(0, 6)], 8'($urandom_range(0, 255)),
                  int'($urandom_range(1, 3)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
